// File: rtl/regfile_sb_pkg.sv
// Shared defaults and write-mode encodings for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int WIDTH        = 32;
    localparam int REG_ADDR_LEN = 5;
    localparam int NUM_REGS     = 32;

    localparam logic [1:0] WR_MODE_WORD = 2'd0;
    localparam logic [1:0] WR_MODE_HALF = 2'd1;
    localparam logic [1:0] WR_MODE_BYTE = 2'd2;

endpackage

// File: rtl/regfile_wr_fmt.sv
// Write-data formatter: word/half/byte selection with zero or sign extension.
// Feeds both the array write port and the same-cycle read forwarding path.
module regfile_wr_fmt #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       mode,
    input  logic             sext,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] fmt,
    output logic             ok
);
    import regfile_sb_pkg::*;

    always_comb begin
        fmt = data;
        ok  = 1'b1;
        unique case (mode)
            WR_MODE_WORD: fmt = data;
            WR_MODE_HALF: fmt = {{(WIDTH-16){sext & data[15]}}, data[15:0]};
            WR_MODE_BYTE: fmt = {{(WIDTH-8){sext & data[7]}}, data[7:0]};
            default:      ok  = 1'b0;
        endcase
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb #(
    parameter int WIDTH    = regfile_sb_pkg::WIDTH,
    parameter int NUM_REGS = regfile_sb_pkg::NUM_REGS,
    parameter int ADDR_LEN = regfile_sb_pkg::REG_ADDR_LEN,
    parameter int NUM_RD   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_LEN-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_LEN-1:0]        wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [1:0]                 wr_mode,
    input  logic                       wr_sext,
    input  logic                       rsv_en,
    input  logic [ADDR_LEN-1:0]        rsv_addr,
    output logic [NUM_REGS-1:0]        busy_vec
);
    import regfile_sb_pkg::*;

    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nx;
    logic [WIDTH-1:0]    wr_fmt;
    logic                fmt_ok;
    logic                wr_ok;
    logic                rsv_ok;
    logic [WIDTH-1:0]    rdat_nx [NUM_RD];
    logic [NUM_RD-1:0]   rbsy_nx;
    logic [ADDR_LEN-1:0] ra;

    function automatic logic live(input logic [ADDR_LEN-1:0] a);
        return (a != '0) && (32'(a) < 32'(NUM_REGS));
    endfunction

    regfile_wr_fmt #(.WIDTH(WIDTH)) u_fmt (
        .mode (wr_mode),
        .sext (wr_sext),
        .data (wr_data),
        .fmt  (wr_fmt),
        .ok   (fmt_ok)
    );

    assign wr_ok    = wr_en && fmt_ok && live(wr_addr);
    assign rsv_ok   = rsv_en && live(rsv_addr);
    assign busy_vec = busy;

    // Reserve is applied after the clear: it marks a newer producer.
    always_comb begin
        busy_nx = busy;
        if (wr_ok)
            busy_nx[wr_addr] = 1'b0;
        if (rsv_ok)
            busy_nx[rsv_addr] = 1'b1;
        busy_nx[0] = 1'b0;
    end

    always_comb begin
        ra = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra         = rd_addr[p*ADDR_LEN +: ADDR_LEN];
            rdat_nx[p] = '0;
            rbsy_nx[p] = 1'b0;
            if (live(ra)) begin
                rdat_nx[p] = regs[ra];
                rbsy_nx[p] = busy[ra];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && wr_addr == ra) begin
                rdat_nx[p] = wr_fmt;
                rbsy_nx[p] = busy_nx[ra];
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok)
                regs[wr_addr] <= wr_fmt;
            busy <= busy_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
            rd_busy  <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_valid[p] <= rd_en[p];
                if (rd_en[p]) begin
                    rd_data[p*WIDTH +: WIDTH] <= rdat_nx[p];
                    rd_busy[p]                <= rbsy_nx[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb against an array-based model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_mode;
    logic        wr_sext;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [31:0] e_data [2];
    logic        e_valid [2];
    logic        e_busy [2];

    regfile_sb dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_mode  (wr_mode),
        .wr_sext  (wr_sext),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fmt_m(logic [31:0] d, logic [1:0] m, logic s);
        logic [31:0] v;
        case (m)
            2'd0: return d;
            2'd1: begin
                v = d % 65536;
                return (s && v >= 32'h8000) ? v + 32'hFFFF_0000 : v;
            end
            2'd2: begin
                v = d % 256;
                return (s && v >= 32'h80) ? v + 32'hFFFF_FF00 : v;
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            e_data[p]  = '0;
            e_valid[p] = 1'b0;
            e_busy[p]  = 1'b0;
        end
    endtask

    task automatic idle();
        rd_en    = '0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_mode  = 2'd0;
        wr_sext  = 1'b0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
        rd_en   = 2'b11;
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic [1:0] m, input logic s);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_mode = m;
        wr_sext = s;
    endtask

    // One clock: model the edge from the sampled inputs, then compare.
    task automatic tick();
        bit          wv;
        logic [31:0] fv;
        bit          nb [32];
        logic [4:0]  a;
        @(posedge clk);
        wv = wr_en && wr_mode != 2'd3 && wr_addr != 0;
        fv = fmt_m(wr_data, wr_mode, wr_sext);
        nb = m_busy;
        if (wv) nb[wr_addr] = 1'b0;
        if (rsv_en && rsv_addr != 0) nb[rsv_addr] = 1'b1;
        for (int p = 0; p < 2; p++) begin
            e_valid[p] = rd_en[p];
            if (rd_en[p]) begin
                a = rd_addr[p*5 +: 5];
                e_data[p] = (a == 0) ? 32'h0 : m_regs[a];
                e_busy[p] = m_busy[a];
`ifdef REGFILE_BYPASS_EN
                if (wv && wr_addr == a) begin
                    e_data[p] = fv;
                    e_busy[p] = nb[a];
                end
`endif
            end
        end
        if (wv) m_regs[wr_addr] = fv;
        m_busy = nb;
        #1;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("valid%0d", p), 64'(rd_valid[p]), 64'(e_valid[p]));
            chk($sformatf("data%0d", p), 64'(rd_data[p*32 +: 32]), 64'(e_data[p]));
            chk($sformatf("busy%0d", p), 64'(rd_busy[p]), 64'(e_busy[p]));
        end
        for (int i = 0; i < 32; i++)
            chk($sformatf("busy_vec[%0d]", i), 64'(busy_vec[i]), 64'(m_busy[i]));
        idle();
    endtask

    initial begin
        model_clear();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_vec", 64'(busy_vec), 64'h0);
        chk("rst_rd_valid", 64'(rd_valid), 64'h0);
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_rd_busy", 64'(rd_busy), 64'h0);
        rst = 1'b0;

        rd2(5, 5); tick();
        chk("r5_data", rd_data, 64'h0);
        chk("r5_valid", 64'(rd_valid), 64'h3);

        wr(3, 32'hDEAD_BEEF, 2'd0, 1'b0); tick();
        rd2(3, 3); tick();
        chk("r3_word", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        chk("r3_same_p1", 64'(rd_data[63:32]), 64'hDEAD_BEEF);

        wr(4, 32'h0000_80F0, 2'd1, 1'b1); tick();
        rd2(4, 0); tick();
        chk("r4_half_sext", 64'(rd_data[31:0]), 64'hFFFF_80F0);

        wr(4, 32'h0000_80F0, 2'd2, 1'b0); tick();
        rd2(4, 4); tick();
        chk("r4_byte_zext", 64'(rd_data[31:0]), 64'h0000_00F0);

        wr(0, 32'h1234, 2'd0, 1'b0); rsv_en = 1'b1; rsv_addr = 0; tick();
        rd2(0, 0); tick();
        chk("r0_zero", rd_data, 64'h0);
        chk("r0_not_busy", 64'(busy_vec[0]), 64'h0);

        wr(7, 32'h77, 2'd0, 1'b0); tick();
        wr(7, 32'hFFFF, 2'd3, 1'b1); tick();
        rd2(7, 7); tick();
        chk("r7_mode3", 64'(rd_data[31:0]), 64'h77);

        rsv_en = 1'b1; rsv_addr = 9; tick();
        chk("r9_rsv", 64'(busy_vec[9]), 64'h1);
        rsv_en = 1'b1; rsv_addr = 9; wr(7, 32'h1, 2'd3, 1'b0); tick();
        rd2(9, 9); tick();
        chk("r9_rd_busy", 64'(rd_busy), 64'h3);
        wr(9, 32'h99, 2'd0, 1'b0); tick();
        chk("r9_clr", 64'(busy_vec[9]), 64'h0);
        wr(9, 32'h1234, 2'd0, 1'b0); rsv_en = 1'b1; rsv_addr = 9; tick();
        chk("r9_rsv_wins", 64'(busy_vec[9]), 64'h1);
        rd2(9, 9); tick();
        chk("r9_data", 64'(rd_data[31:0]), 64'h1234);

        wr(12, 32'h11, 2'd0, 1'b0); tick();
        wr(12, 32'hA5, 2'd0, 1'b0); rd2(12, 12); tick();
`ifdef REGFILE_BYPASS_EN
        chk("r12_bypass", 64'(rd_data[31:0]), 64'hA5);
`else
        chk("r12_nobypass", 64'(rd_data[31:0]), 64'h11);
`endif
        rd2(12, 12); tick();
        chk("r12_after", 64'(rd_data[31:0]), 64'hA5);

        wr(20, 32'h55, 2'd0, 1'b0); rsv_en = 1'b1; rsv_addr = 21; rd2(3, 9); tick();
        rst = 1'b1;
        #1;
        model_clear();
        chk("mid_rst_busy_vec", 64'(busy_vec), 64'h0);
        chk("mid_rst_data", rd_data, 64'h0);
        chk("mid_rst_valid", 64'(rd_valid), 64'h0);
        chk("mid_rst_busy", 64'(rd_busy), 64'h0);
        #1;
        rst = 1'b0;
        rd2(20, 3); tick();
        chk("post_rst_data", rd_data, 64'h0);
        chk("post_rst_busy", 64'(rd_busy), 64'h0);

        for (int n = 0; n < 400; n++) begin
            rd_en    = 2'($urandom_range(0, 3));
            rd_addr  = 10'($urandom);
            wr_en    = 1'($urandom);
            wr_addr  = 5'($urandom);
            wr_data  = $urandom;
            wr_mode  = 2'($urandom);
            wr_sext  = 1'($urandom);
            rsv_en   = ($urandom_range(0, 3) == 0);
            rsv_addr = (n % 5 == 0) ? wr_addr : 5'($urandom);
            if (n % 7 == 0) rd_addr = {wr_addr, wr_addr};
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
